// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the single-bus datapath.
//   bus_src_e      bus source codes driven by the control unit
//   LD_*           bit positions inside the ld_en strobe vector
//   fetch_state_e  states of the built-in instruction-fetch sequencer
//   low_mask / ir_field / sign_ext  IR field extraction helpers, written on a
//   MAX_W-bit carrier so one set of functions serves any WIDTH up to 64.
package datapath_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    BS_NONE   = 4'd0,
    BS_RF     = 4'd1,
    BS_HI     = 4'd2,
    BS_LO     = 4'd3,
    BS_ZHI    = 4'd4,
    BS_ZLO    = 4'd5,
    BS_PC     = 4'd6,
    BS_MDR    = 4'd7,
    BS_INPORT = 4'd8,
    BS_CSX    = 4'd9
  } bus_src_e;

  localparam int LD_RF   = 0;
  localparam int LD_HI   = 1;
  localparam int LD_LO   = 2;
  localparam int LD_Y    = 3;
  localparam int LD_Z    = 4;
  localparam int LD_PC   = 5;
  localparam int LD_IR   = 6;
  localparam int LD_MAR  = 7;
  localparam int LD_MDR  = 8;
  localparam int LD_OUTP = 9;
  localparam int LD_W    = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_ADDR = 2'd1,
    F_WAIT = 2'd2,
    F_IR   = 2'd3
  } fetch_state_e;

  // Mask with the low len bits set.
  function automatic logic [MAX_W-1:0] low_mask(input int len);
    if (len >= MAX_W) return '1;
    return (MAX_W'(1) << len) - MAX_W'(1);
  endfunction

  // Unsigned field of len bits starting at bit lsb.
  function automatic logic [MAX_W-1:0] ir_field(input logic [MAX_W-1:0] word,
                                                input int lsb, input int len);
    return (word >> lsb) & low_mask(len);
  endfunction

  // Sign-extend the low nbits of word to the full carrier width.
  function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] word,
                                                input int nbits);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] t;
    m = low_mask(nbits);
    t = (nbits > 0) ? (word >> (nbits - 1)) : '0;
    if (nbits > 0 && t[0]) return word | ~m;
    return word & m;
  endfunction

endpackage

// File: rtl/param_datapath_reg_file.sv
// reg_file: NREGS x WIDTH general register file.
//   clk, rst_n      clock, asynchronous active-low reset (clears every register)
//   we, waddr,wdata single write port
//   raddr, rdata    single combinational read port
//   ba_zero         when set, register 0 reads as zero (R0 still stores writes)
module reg_file #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  input  logic             ba_zero,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rdata = (ba_zero && raddr == '0) ? '0 : rf_q[raddr];

endmodule

// File: rtl/param_datapath.sv
// param_datapath: single-bus CPU datapath with register file, HI/LO, Y/Z,
// PC/IR/MAR/MDR, I/O ports, req/ack memory handshake and a fetch sequencer.
//   clock, clear          clock, asynchronous active-low reset
//   bus_src, ld_en        bus source select and per-register load strobes
//   gra/grb/grc, ba_out   register-field select (gra > grb > grc), R0-as-zero
//   inc_pc                PC increment
//   mem_rd/wr_start       launch a memory read/write at MAR
//   mem_req/we/addr/wdata memory request side; mem_rdata/mem_ack response side
//   busy                  memory transaction or fetch in progress
//   fetch_start/done      fetch sequencer start and one-cycle completion pulse
//   alu_a/alu_b           Y and bus towards the external ALU; alu_result -> Z
//   in/out_port_data, ir  I/O ports and instruction register
module param_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [3:0]         bus_src,
  input  logic [LD_W-1:0]    ld_en,
  input  logic               gra,
  input  logic               grb,
  input  logic               grc,
  input  logic               ba_out,
  input  logic               inc_pc,
  input  logic               mem_rd_start,
  input  logic               mem_wr_start,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack,
  output logic               busy,
  input  logic               fetch_start,
  output logic               fetch_done,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [2*WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0]   in_port_data,
  output logic [WIDTH-1:0]   out_port_data,
  output logic [WIDTH-1:0]   ir
);

  localparam int AW     = $clog2(NREGS);
  localparam int RA_LSB = WIDTH - 5 - AW;
  localparam int RB_LSB = RA_LSB - AW;
  localparam int RC_LSB = RB_LSB - AW;
  localparam int C_BITS = WIDTH - 5 - 2 * AW;

  fetch_state_e       state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, y_q, y_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [WIDTH-1:0]   outp_q, outp_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic               fetch_done_q, fetch_done_d;

  logic [WIDTH-1:0]   bus, rf_rdata, csx;
  logic [AW-1:0]      ra, rb, rc, rf_sel;
  logic               sel_valid, rf_we;
  logic               idle, ack_hit, fetch_go, start_ok;
  logic [LD_W-1:0]    ld;
  logic [MAX_W-1:0]   ir_ext;
  bus_src_e           src;

  assign ir_ext = MAX_W'(ir_q);
  assign ra     = AW'(ir_field(ir_ext, RA_LSB, AW));
  assign rb     = AW'(ir_field(ir_ext, RB_LSB, AW));
  assign rc     = AW'(ir_field(ir_ext, RC_LSB, AW));
  assign csx    = WIDTH'(sign_ext(ir_ext, C_BITS));
  assign src    = bus_src_e'(bus_src);

  always_comb begin
    sel_valid = gra | grb | grc;
    rf_sel    = gra ? ra : (grb ? rb : rc);
  end

  reg_file #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk     (clock),
    .rst_n   (clear),
    .we      (rf_we),
    .waddr   (rf_sel),
    .wdata   (bus),
    .raddr   (rf_sel),
    .ba_zero (ba_out),
    .rdata   (rf_rdata)
  );

  always_comb begin
    bus = '0;
    case (src)
      BS_RF:     bus = sel_valid ? rf_rdata : '0;
      BS_HI:     bus = hi_q;
      BS_LO:     bus = lo_q;
      BS_ZHI:    bus = z_q[2*WIDTH-1:WIDTH];
      BS_ZLO:    bus = z_q[WIDTH-1:0];
      BS_PC:     bus = pc_q;
      BS_MDR:    bus = mdr_q;
      BS_INPORT: bus = in_port_data;
      BS_CSX:    bus = csx;
      default:   bus = '0;
    endcase
  end

  always_comb begin
    idle     = (state_q == IDLE);
    ack_hit  = mem_req_q && mem_ack;
    fetch_go = idle && !mem_req_q && fetch_start;
    // A fetch start takes the cycle; memory strobes in that same cycle are dropped.
    start_ok = idle && !mem_req_q && !fetch_start;
    // Control strobes only act while the fetch sequencer is idle.
    ld       = idle ? ld_en : '0;
    rf_we    = ld[LD_RF] && sel_valid;

    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    y_d          = y_q;
    z_d          = z_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    outp_d       = outp_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    fetch_done_d = 1'b0;

    case (state_q)
      IDLE:    if (fetch_go) state_d = F_ADDR;
      F_ADDR:  state_d = F_WAIT;
      F_WAIT:  if (ack_hit) state_d = F_IR;
      F_IR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ld[LD_HI])   hi_d   = bus;
    if (ld[LD_LO])   lo_d   = bus;
    if (ld[LD_Y])    y_d    = bus;
    if (ld[LD_Z])    z_d    = alu_result;
    if (ld[LD_OUTP]) outp_d = bus;

    if (state_q == F_ADDR)   pc_d = pc_q + WIDTH'(1);
    else if (ld[LD_PC])      pc_d = bus;
    else if (idle && inc_pc) pc_d = pc_q + WIDTH'(1);

    if (state_q == F_ADDR) mar_d = pc_q;
    else if (ld[LD_MAR])   mar_d = bus;

    if (state_q == F_IR) ir_d = mdr_q;
    else if (ld[LD_IR])  ir_d = bus;

    if (ack_hit && !mem_we_q) mdr_d = mem_rdata;
    else if (ld[LD_MDR])      mdr_d = bus;

    fetch_done_d = (state_q == F_IR);

    // Request stays up until an ack is sampled; a stray ack with no request does nothing.
    if (ack_hit) begin
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end else if (state_q == F_ADDR) begin
      mem_req_d = 1'b1;
      mem_we_d  = 1'b0;
    end else if (start_ok && mem_rd_start) begin
      mem_req_d = 1'b1;
      mem_we_d  = 1'b0;
    end else if (start_ok && mem_wr_start) begin
      mem_req_d = 1'b1;
      mem_we_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      y_q          <= '0;
      z_q          <= '0;
      pc_q         <= '0;
      ir_q         <= '0;
      mar_q        <= '0;
      mdr_q        <= '0;
      outp_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      y_q          <= y_d;
      z_q          <= z_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      outp_q       <= outp_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mar_q;
  assign mem_wdata     = mdr_q;
  assign busy          = mem_req_q || (state_q != IDLE);
  assign fetch_done    = fetch_done_q;
  assign alu_a         = y_q;
  assign alu_b         = bus;
  assign out_port_data = outp_q;
  assign ir            = ir_q;

endmodule
